// File: rtl/soc2_uart_pkg.sv
// Shared definitions for the soc2 UART transmit and receive paths.
package soc2_uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/soc2_sync_fifo.sv
// Synchronous FIFO with registered occupancy count; full/empty come from the count.
module soc2_sync_fifo
  import soc2_uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_BITS,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  // A push while full is dropped even when a pop shares the edge.
  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign dout      = r_mem[r_rd_ptr];
  assign count     = r_count;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/soc2_uart_tx.sv
// 8N1 UART transmitter: write FIFO feeding a baud-timed start/data/stop serializer.
module soc2_uart_tx
  import soc2_uart_pkg::*;
#(
  parameter int BAUD_DIV   = 217,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int                BAUD_W    = $clog2(BAUD_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_state_t                  r_state;
  uart_state_t                  w_state_nxt;
  logic [BAUD_W-1:0]            r_baud;
  logic [BAUD_W-1:0]            w_baud_nxt;
  logic [2:0]                   r_bit_idx;
  logic [2:0]                   w_bit_idx_nxt;
  logic [7:0]                   r_shift;
  logic [7:0]                   w_shift_nxt;
  logic                         r_tx;
  logic                         w_tx_nxt;
  logic                         w_bit_end;
  logic                         w_pop;
  logic                         w_full;
  logic                         w_empty;
  logic [7:0]                   w_fifo_dout;
  logic [$clog2(FIFO_DEPTH):0]  w_count;

  soc2_sync_fifo #(
    .DATA_W (UART_DATA_BITS),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (wr_valid),
    .pop    (w_pop),
    .din    (wr_data),
    .dout   (w_fifo_dout),
    .full   (w_full),
    .empty  (w_empty),
    .count  (w_count)
  );

  assign w_bit_end = (r_baud == BAUD_LAST);
  assign wr_ready  = !w_full;
  assign uart_tx   = r_tx;
  assign fifo_cnt  = w_count;
  assign busy      = (r_state != ST_IDLE) || (w_count != '0);

  // Next-state logic; the line level for the coming bit is decided here and registered.
  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = w_bit_end ? '0 : r_baud + 1'b1;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_tx_nxt      = r_tx;
    w_pop         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_baud_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_dout;
          w_state_nxt = ST_START;
          w_tx_nxt    = 1'b0;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt   = ST_DATA;
          w_bit_idx_nxt = '0;
          w_tx_nxt      = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == BIT_LAST) begin
            w_state_nxt = ST_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
            w_shift_nxt   = {1'b0, r_shift[7:1]};
            w_tx_nxt      = r_shift[1];
          end
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_dout;
            w_state_nxt = ST_START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  // Control state and the line flop; reset drops any frame in flight and idles the line high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  // Shift register holds payload only; its value is never observed outside a frame.
  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
  end

endmodule

// File: tb/tb_soc2_uart_tx.sv
// Self-checking bench for soc2_uart_tx with BAUD_DIV=4, FIFO_DEPTH=4.
module tb_soc2_uart_tx;

  localparam int B    = 4;
  localparam int LOGN = 8192;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready;
  logic       uart_tx;
  logic       busy;
  logic [2:0] fifo_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_q [$];
  logic [7:0] stim [8];

  logic       tx_at   [LOGN];
  logic       busy_at [LOGN];
  logic       rdy_at  [LOGN];
  logic [2:0] cnt_at  [LOGN];

  soc2_uart_tx #(.BAUD_DIV(B), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .uart_tx  (uart_tx),
    .busy     (busy),
    .fifo_cnt (fifo_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Entry k holds the outputs as they stand after rising edge k.
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      tx_at[cyc]   <= uart_tx;
      busy_at[cyc] <= busy;
      rdy_at[cyc]  <= wr_ready;
      cnt_at[cyc]  <= fifo_cnt;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int edge_no);
    while (cyc <= edge_no) step();
  endtask

  task automatic push_run(input int n, output int first_edge, output int n_acc);
    logic rdy;
    int   e;
    n_acc = 0;
    first_edge = -1;
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = stim[i];
      #1;
      rdy = wr_ready;
      e   = cyc + 1;
      step();
      if (rdy) begin
        exp_q.push_back(stim[i]);
        n_acc++;
        if (first_edge < 0) first_edge = e;
      end
    end
    wr_valid = 1'b0;
    wr_data  = 8'h00;
  endtask

  task automatic check_frames(input string tag, input int s, input int n);
    logic [9:0] obs;
    logic [9:0] expf;
    logic [7:0] e;
    logic       stable;
    int         base;
    for (int f = 0; f < n; f++) begin
      base   = s + f * 10 * B;
      obs    = '0;
      stable = 1'b1;
      for (int k = 0; k < 10; k++) begin
        obs[k] = tx_at[base + k * B];
        for (int j = 1; j < B; j++)
          if (tx_at[base + k * B + j] !== obs[k]) stable = 1'b0;
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL %s frame%0d: got %b but scoreboard is empty", tag, f, obs);
      end else begin
        e    = exp_q.pop_front();
        expf = {1'b1, e, 1'b0};
        if (obs !== expf || !stable) begin
          bad++;
          $display("FAIL %s frame%0d: got %b stable=%0b, want %b (byte %02h)", tag, f, obs, stable, expf, e);
        end
      end
    end
  endtask

  task automatic test_reset();
    wr_valid = 1'b0;
    #2 resetn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({uart_tx, wr_ready, busy, fifo_cnt} !== {1'b1, 1'b1, 1'b0, 3'd0}) begin
        bad++;
        $display("FAIL reset_c%0d: tx=%b rdy=%b busy=%b cnt=%0d, want tx=1 rdy=1 busy=0 cnt=0", i, uart_tx, wr_ready, busy, fifo_cnt);
      end
    end
    @(posedge clk);
    #1 resetn = 1'b1;
    step();
  endtask

  task automatic test_single();
    int n, acc, s;
    stim[0] = 8'h5A;
    push_run(1, n, acc);
    s = n + 1;
    total++;
    if (fifo_cnt !== 3'd1) begin
      bad++;
      $display("FAIL single_cnt_after_accept: got %0d want 1", fifo_cnt);
    end
    step();
    total++;
    if ({uart_tx, fifo_cnt} !== {1'b0, 3'd0}) begin
      bad++;
      $display("FAIL single_start: tx=%b cnt=%0d, want tx=0 cnt=0", uart_tx, fifo_cnt);
    end
    wait_until(s + 10 * B + 2);
    total++;
    if (tx_at[n] !== 1'b1) begin
      bad++;
      $display("FAIL single_tx_on_accept_edge: got %b want 1", tx_at[n]);
    end
    check_frames("single", s, 1);
    total++;
    if ({busy_at[s + 10 * B - 1], busy_at[s + 10 * B]} !== 2'b10) begin
      bad++;
      $display("FAIL single_busy_fall: got %b%b want 10", busy_at[s + 10 * B - 1], busy_at[s + 10 * B]);
    end
  endtask

  task automatic test_fill();
    int n, acc, s;
    for (int i = 0; i < 5; i++) stim[i] = 8'(i + 1);
    push_run(5, n, acc);
    s = n + 1;
    total++;
    if (acc !== 5) begin
      bad++;
      $display("FAIL fill_accepts: got %0d want 5", acc);
    end
    wait_until(s + 50 * B + 2);
    total++;
    if ({rdy_at[n + 3], rdy_at[n + 4], cnt_at[n + 4]} !== {1'b1, 1'b0, 3'd4}) begin
      bad++;
      $display("FAIL fill_full: rdy %b->%b cnt=%0d, want 1->0 cnt=4", rdy_at[n + 3], rdy_at[n + 4], cnt_at[n + 4]);
    end
    total++;
    if ({rdy_at[s + 10 * B - 1], rdy_at[s + 10 * B]} !== 2'b01) begin
      bad++;
      $display("FAIL fill_ready_back: got %b%b want 01", rdy_at[s + 10 * B - 1], rdy_at[s + 10 * B]);
    end
    check_frames("fill", s, 5);
    total++;
    if ({busy_at[s + 50 * B - 1], busy_at[s + 50 * B], tx_at[s + 50 * B]} !== 3'b101) begin
      bad++;
      $display("FAIL fill_drain: busy %b->%b tx=%b, want 1->0 tx=1", busy_at[s + 50 * B - 1], busy_at[s + 50 * B], tx_at[s + 50 * B]);
    end
  endtask

  task automatic test_full_pop();
    int   n, acc, s, ep, acc_edge, e;
    logic rdy;
    for (int i = 0; i < 5; i++) stim[i] = 8'(8'h30 + i);
    push_run(5, n, acc);
    s  = n + 1;
    ep = s + 10 * B;
    acc_edge = -1;
    while (cyc < ep - 3) step();
    for (int t = 0; t < 20 && acc_edge < 0; t++) begin
      wr_valid = 1'b1;
      wr_data  = 8'hEE;
      #1;
      rdy = wr_ready;
      e   = cyc + 1;
      step();
      if (rdy) begin
        acc_edge = e;
        exp_q.push_back(8'hEE);
      end
    end
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    total++;
    if (acc_edge !== ep + 1) begin
      bad++;
      $display("FAIL fullpop_accept_edge: got %0d want %0d", acc_edge, ep + 1);
    end
    wait_until(s + 60 * B + 2);
    total++;
    if ({cnt_at[ep - 1], cnt_at[ep], cnt_at[ep + 1]} !== {3'd4, 3'd3, 3'd4}) begin
      bad++;
      $display("FAIL fullpop_cnt: got %0d,%0d,%0d want 4,3,4", cnt_at[ep - 1], cnt_at[ep], cnt_at[ep + 1]);
    end
    check_frames("fullpop", s, 6);
    total++;
    if (busy_at[s + 60 * B] !== 1'b0) begin
      bad++;
      $display("FAIL fullpop_drain: busy=%b want 0", busy_at[s + 60 * B]);
    end
  endtask

  task automatic test_reset_mid();
    int   n, acc, s;
    logic low_seen;
    stim[0] = 8'hC3;
    stim[1] = 8'hA1;
    stim[2] = 8'hB2;
    push_run(3, n, acc);
    s = n + 1;
    while (cyc < s + 4 * B + 1) step();
    total++;
    if ({uart_tx, fifo_cnt} !== {1'b0, 3'd2}) begin
      bad++;
      $display("FAIL rstmid_before: tx=%b cnt=%0d, want tx=0 cnt=2", uart_tx, fifo_cnt);
    end
    resetn = 1'b0;
    #1;
    total++;
    if ({uart_tx, fifo_cnt, busy, wr_ready} !== {1'b1, 3'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL rstmid_async: tx=%b cnt=%0d busy=%b rdy=%b, want tx=1 cnt=0 busy=0 rdy=1", uart_tx, fifo_cnt, busy, wr_ready);
    end
    exp_q.delete();
    step();
    step();
    resetn = 1'b1;
    low_seen = 1'b0;
    for (int i = 0; i < 15 * B; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0) low_seen = 1'b1;
    end
    total++;
    if (low_seen !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_quiet: activity after release=%b want 0", low_seen);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
